// File: rtl/paint_pkg.sv
// Shared paint-path types and constants, used by the command decoder,
// the pixel store and the colour decode.
package paint_pkg;

  localparam int         COORD_W     = 10;
  localparam int         X_MAX_DEF   = 640;
  localparam int         Y_MAX_DEF   = 480;
  localparam int         TIMEOUT_DEF = 25175;
  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  // Bit positions inside the sticky error vector {overrun, timeout, range, cksum, sync}.
  localparam int ERR_W       = 5;
  localparam int ERR_SYNC    = 0;
  localparam int ERR_CKSUM   = 1;
  localparam int ERR_RANGE   = 2;
  localparam int ERR_TIMEOUT = 3;
  localparam int ERR_OVERRUN = 4;

  typedef logic [2:0]         color_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   brush;
    color_t color;
    coord_t x;
    coord_t y;
  } paint_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_XLO,
    ST_YLO,
    ST_CK
  } dec_state_e;

  function automatic logic coord_ok(coord_t c, int unsigned lim);
    return {{(32-COORD_W){1'b0}}, c} < lim;
  endfunction

endpackage

// File: rtl/paint_cmd_decoder_if.sv
// Byte-stream input and paint-command output bundle of the command decoder.
interface paint_cmd_decoder_if;
  import paint_pkg::*;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_brush;
  color_t     cmd_color;
  coord_t     cmd_x;
  coord_t     cmd_y;

  modport master (
    output byte_valid, byte_data, cmd_ready,
    input  cmd_valid, cmd_brush, cmd_color, cmd_x, cmd_y
  );

  modport slave (
    input  byte_valid, byte_data, cmd_ready,
    output cmd_valid, cmd_brush, cmd_color, cmd_x, cmd_y
  );

endinterface

// File: rtl/paint_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while a frame is open and pulses
// on the cycle the allowed gap runs out.
module paint_gap_timer #(
  parameter int TIMEOUT_CYCLES = 25175
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic byte_i,
  output logic expire_o
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte on the expiry cycle wins, so expiry is gated by byte_i.
  always_comb begin
    expire_o = en_i && !byte_i && (cnt_q == LAST);
    cnt_d    = cnt_q + CW'(1);
    if (!en_i || byte_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/paint_cmd_decoder.sv
// Paint frame decoder: assembles 5-byte frames from the SPI byte stream,
// validates them and hands one paint command at a time to the pixel store.
//   state   | meaning
//   IDLE    | hunting for a header byte
//   HI      | expecting the coordinate high bits
//   XLO/YLO | expecting the x / y low byte
//   CK      | expecting the checksum; the frame is judged on this byte
module paint_cmd_decoder
  import paint_pkg::*;
#(
  parameter int         X_MAX          = X_MAX_DEF,
  parameter int         Y_MAX          = Y_MAX_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [3:0] HDR_TAG        = HDR_TAG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  paint_cmd_decoder_if.slave bus,
  input  logic               clear_err,
  output logic [ERR_W-1:0]   err_flags,
  output logic [7:0]         drop_count
);

  dec_state_e       state_q;
  logic             brush_q;
  color_t           color_q;
  coord_t           x_q, y_q;
  logic [7:0]       xor_q;
  paint_cmd_t       cmd_q;
  logic             cmd_valid_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       drop_q, drop_d;

  logic             bv;
  logic [7:0]       bd;
  logic             tmr_expire;
  logic             hdr_ok, ck_bad, rng_bad, out_busy, ck_evt, load, sync_set;
  logic [ERR_W-1:0] drop_set;

  assign bv = bus.byte_valid;
  assign bd = bus.byte_data;

  paint_gap_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_gap (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q != ST_IDLE),
    .byte_i   (bv),
    .expire_o (tmr_expire)
  );

  // Frame judgement in priority order; at most one drop reason per frame.
  always_comb begin
    hdr_ok   = (bd[7:4] == HDR_TAG);
    ck_bad   = (bd != xor_q);
    rng_bad  = !coord_ok(x_q, X_MAX) || !coord_ok(y_q, Y_MAX);
    out_busy = cmd_valid_q && !bus.cmd_ready;
    ck_evt   = (state_q == ST_CK) && bv;
    sync_set = (state_q == ST_IDLE) && bv && !hdr_ok;
    drop_set = '0;
    if (tmr_expire) begin
      drop_set[ERR_TIMEOUT] = 1'b1;
    end else if (ck_evt) begin
      if (ck_bad)        drop_set[ERR_CKSUM]   = 1'b1;
      else if (rng_bad)  drop_set[ERR_RANGE]   = 1'b1;
      else if (out_busy) drop_set[ERR_OVERRUN] = 1'b1;
    end
    load = ck_evt && !ck_bad && !rng_bad && !out_busy;

    err_d           = err_q | drop_set;
    err_d[ERR_SYNC] = err_d[ERR_SYNC] | sync_set;
    drop_d          = drop_q;
    if ((|drop_set) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    if (clear_err) begin
      err_d  = '0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      brush_q     <= 1'b0;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      xor_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= '0;
      drop_q      <= '0;
    end else begin
      err_q  <= err_d;
      drop_q <= drop_d;

      // A transfer and a fresh load in the same cycle keeps cmd_valid high.
      if (load) begin
        cmd_q.brush <= brush_q;
        cmd_q.color <= color_q;
        cmd_q.x     <= x_q;
        cmd_q.y     <= y_q;
        cmd_valid_q <= 1'b1;
      end else if (cmd_valid_q && bus.cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end

      if (tmr_expire) begin
        state_q <= ST_IDLE;
      end else if (bv) begin
        case (state_q)
          ST_IDLE: begin
            if (hdr_ok) begin
              brush_q <= bd[3];
              color_q <= bd[2:0];
              xor_q   <= bd;
              state_q <= ST_HI;
            end
          end
          ST_HI: begin
            x_q     <= {bd[5:4], x_q[7:0]};
            y_q     <= {bd[1:0], y_q[7:0]};
            xor_q   <= xor_q ^ bd;
            state_q <= ST_XLO;
          end
          ST_XLO: begin
            x_q     <= {x_q[COORD_W-1:8], bd};
            xor_q   <= xor_q ^ bd;
            state_q <= ST_YLO;
          end
          ST_YLO: begin
            y_q     <= {y_q[COORD_W-1:8], bd};
            xor_q   <= xor_q ^ bd;
            state_q <= ST_CK;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_brush = cmd_q.brush;
  assign bus.cmd_color = cmd_q.color;
  assign bus.cmd_x     = cmd_q.x;
  assign bus.cmd_y     = cmd_q.y;
  assign err_flags     = err_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_paint_cmd_decoder.sv
// Self-checking bench for paint_cmd_decoder: directed frames plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_paint_cmd_decoder;
  import paint_pkg::*;

  localparam int TMO = TIMEOUT_DEF;
  localparam logic [39:0] GOOD = 40'hAD_00_64_C8_01;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_err;
  logic [4:0] err_flags;
  logic [7:0] drop_count;
  bit         rnd_mode;
  int         n_total = 0;
  int         n_bad   = 0;

  paint_cmd_decoder_if bus();

  paint_cmd_decoder #(
    .X_MAX (X_MAX_DEF), .Y_MAX (Y_MAX_DEF), .TIMEOUT_CYCLES (TMO), .HDR_TAG (HDR_TAG_DEF)
  ) dut (
    .clk (clk), .reset (reset), .bus (bus),
    .clear_err (clear_err), .err_flags (err_flags), .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: open frame as a byte queue, idle-cycle count since last byte.
  logic [7:0] m_q[$];
  int         m_gap;
  bit         m_valid;
  bit         m_brush;
  logic [2:0] m_color;
  logic [9:0] m_x, m_y;
  logic [4:0] m_err;
  logic [7:0] m_drop;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_gap = 0; m_valid = 0; m_brush = 0; m_color = '0;
    m_x = '0; m_y = '0; m_err = '0; m_drop = '0;
  endfunction

  function automatic void model_step();
    logic [4:0] set;
    bit load, bv, rdy;
    logic [7:0] bd, b0, b1;
    int x, y;
    set = '0; load = 0;
    bv = bus.byte_valid; bd = bus.byte_data; rdy = bus.cmd_ready;
    if (m_q.size() == 0) begin
      if (bv) begin
        if (bd[7:4] == HDR_TAG_DEF) begin m_q.push_back(bd); m_gap = 0; end
        else set[0] = 1'b1;
      end
    end else if (bv) begin
      m_q.push_back(bd);
      m_gap = 0;
      if (m_q.size() == 5) begin
        b0 = m_q[0]; b1 = m_q[1];
        x = int'(b1[5:4]) * 256 + int'(m_q[2]);
        y = int'(b1[1:0]) * 256 + int'(m_q[3]);
        if ((m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3]) != m_q[4]) set[1] = 1'b1;
        else if (x >= X_MAX_DEF || y >= Y_MAX_DEF)         set[2] = 1'b1;
        else if (m_valid && !rdy)                            set[4] = 1'b1;
        else begin
          load = 1; m_brush = b0[3]; m_color = b0[2:0]; m_x = 10'(x); m_y = 10'(y);
        end
        m_q.delete();
      end
    end else begin
      m_gap++;
      if (m_gap == TMO) begin set[3] = 1'b1; m_q.delete(); m_gap = 0; end
    end
    if (load) m_valid = 1;
    else if (m_valid && rdy) m_valid = 0;
    if (clear_err) begin
      m_err = '0; m_drop = '0;
    end else begin
      m_err = m_err | set;
      if ((|set[4:1]) && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end
  endfunction

  function automatic logic [37:0] exp_vec();
    logic [23:0] c;
    c = '0;
    if (m_valid) c = {m_brush, m_color, m_x, m_y};
    return {m_valid, c, m_err, m_drop};
  endfunction

  function automatic logic [37:0] obs_vec();
    logic [23:0] c;
    c = '0;
    if (bus.cmd_valid) c = {bus.cmd_brush, bus.cmd_color, bus.cmd_x, bus.cmd_y};
    return {bus.cmd_valid, c, err_flags, drop_count};
  endfunction

  task automatic tick();
    if (rnd_mode) begin
      bus.cmd_ready = 1'($urandom_range(0, 1));
      clear_err     = ($urandom_range(0, 47) == 0);
    end
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    #1;
    check("cycle", 64'(obs_vec()), 64'(exp_vec()));
  endtask

  task automatic send_byte(logic [7:0] b, int unsigned gap);
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(logic [39:0] f, int unsigned gap);
    for (int k = 0; k < 5; k++) send_byte(f[39-8*k -: 8], (k == 0) ? gap : $urandom_range(0, gap));
  endtask

  function automatic logic [39:0] mk_frame(logic brush, logic [2:0] color, logic [9:0] x, logic [9:0] y);
    logic [7:0] b0, b1;
    b0 = {HDR_TAG_DEF, brush, color};
    b1 = {2'b00, x[9:8], 2'b00, y[9:8]};
    return {b0, b1, x[7:0], y[7:0], b0 ^ b1 ^ x[7:0] ^ y[7:0]};
  endfunction

  task automatic drain();
    bus.cmd_ready = 1'b1; tick(); bus.cmd_ready = 1'b0;
  endtask

  task automatic clr();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] f;
    reset = 1'b1; clear_err = 1'b0; rnd_mode = 0;
    bus.byte_valid = 1'b0; bus.byte_data = '0; bus.cmd_ready = 1'b0;
    model_reset();
    repeat (2) tick();
    check("rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_x",     64'(bus.cmd_x), 64'd0);
    check("rst_err",   64'(err_flags), 64'd0);
    check("rst_drop",  64'(drop_count), 64'd0);
    reset = 1'b0;
    tick();

    // good frame, held until accepted
    send_frame(GOOD, 0);
    check("good_valid", 64'(bus.cmd_valid), 64'd1);
    check("good_brush", 64'(bus.cmd_brush), 64'd1);
    check("good_color", 64'(bus.cmd_color), 64'd5);
    check("good_x",     64'(bus.cmd_x), 64'd100);
    check("good_y",     64'(bus.cmd_y), 64'd200);
    repeat (3) tick();
    check("hold_valid", 64'(bus.cmd_valid), 64'd1);
    check("hold_x",     64'(bus.cmd_x), 64'd100);
    drain();
    check("xfer_valid", 64'(bus.cmd_valid), 64'd0);

    // bad checksum
    send_frame(40'hAD_00_64_C8_02, 0);
    check("ck_valid", 64'(bus.cmd_valid), 64'd0);
    check("ck_err",   64'(err_flags), 64'b00010);
    check("ck_drop",  64'(drop_count), 64'd1);
    clr();
    check("clr_err",  64'(err_flags), 64'd0);
    check("clr_drop", 64'(drop_count), 64'd0);

    // range boundaries
    send_frame(mk_frame(1'b1, 3'd5, 10'd640, 10'd0), 0);
    check("rng_x_err",  64'(err_flags), 64'b00100);
    check("rng_x_drop", 64'(drop_count), 64'd1);
    send_frame(mk_frame(1'b1, 3'd5, 10'd639, 10'd0), 0);
    check("x639_valid", 64'(bus.cmd_valid), 64'd1);
    check("x639_x",     64'(bus.cmd_x), 64'd639);
    drain();
    send_frame(mk_frame(1'b0, 3'd2, 10'd0, 10'd480), 0);
    check("rng_y_drop", 64'(drop_count), 64'd2);
    send_frame(mk_frame(1'b0, 3'd2, 10'd0, 10'd479), 0);
    check("y479_y",     64'(bus.cmd_y), 64'd479);
    drain();
    clr();

    // sync loss then good frame
    send_byte(8'h3C, 0);
    check("sync_err",  64'(err_flags), 64'b00001);
    check("sync_drop", 64'(drop_count), 64'd0);
    send_frame(GOOD, 0);
    check("sync_good", 64'(bus.cmd_x), 64'd100);
    drain();
    clr();

    // timeout boundary after B2
    send_byte(8'hAD, 0); send_byte(8'h00, 0); send_byte(8'h64, 0);
    repeat (TMO - 1) tick();
    check("tmo_early", 64'(err_flags), 64'd0);
    tick();
    check("tmo_err",  64'(err_flags), 64'b01000);
    check("tmo_drop", 64'(drop_count), 64'd1);
    send_frame(GOOD, 0);
    check("tmo_next", 64'(bus.cmd_valid), 64'd1);
    drain();
    clr();

    // byte arriving on the expiry cycle
    send_byte(8'hAD, 0); send_byte(8'h00, 0); send_byte(8'h64, 0);
    send_byte(8'hC8, TMO - 1); send_byte(8'h01, 0);
    check("edge_err",   64'(err_flags), 64'd0);
    check("edge_valid", 64'(bus.cmd_valid), 64'd1);
    check("edge_y",     64'(bus.cmd_y), 64'd200);
    drain();

    // overrun, then simultaneous free
    send_frame(mk_frame(1'b1, 3'd1, 10'd10, 10'd20), 0);
    send_frame(mk_frame(1'b1, 3'd1, 10'd11, 10'd21), 0);
    check("ovr_err",  64'(err_flags), 64'b10000);
    check("ovr_drop", 64'(drop_count), 64'd1);
    check("ovr_x",    64'(bus.cmd_x), 64'd10);
    drain();
    clr();
    send_frame(mk_frame(1'b1, 3'd1, 10'd10, 10'd20), 0);
    f = mk_frame(1'b0, 3'd6, 10'd11, 10'd21);
    for (int k = 0; k < 4; k++) send_byte(f[39-8*k -: 8], 0);
    bus.cmd_ready = 1'b1;
    send_byte(f[7:0], 0);
    bus.cmd_ready = 1'b0;
    check("swap_valid", 64'(bus.cmd_valid), 64'd1);
    check("swap_x",     64'(bus.cmd_x), 64'd11);
    check("swap_err",   64'(err_flags), 64'd0);
    drain();

    // drop counter saturation, clear beating a same-cycle drop
    repeat (260) send_frame(40'hAD_00_64_C8_02, 0);
    check("sat_drop", 64'(drop_count), 64'd255);
    check("sat_err",  64'(err_flags), 64'b00010);
    for (int k = 0; k < 4; k++) send_byte(GOOD[39-8*k -: 8], 0);
    clear_err = 1'b1;
    send_byte(8'h02, 0);
    clear_err = 1'b0;
    check("clrwin_drop", 64'(drop_count), 64'd0);
    check("clrwin_err",  64'(err_flags), 64'd0);

    // random traffic
    rnd_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int unsigned kind;
      logic [9:0]  rx, ry;
      logic [7:0]  junk;
      logic [39:0] rf;
      kind = $urandom_range(0, 9);
      rx = 10'($urandom_range(0, 639));
      ry = 10'($urandom_range(0, 479));
      if (kind == 2) rx = 10'($urandom_range(640, 1023));
      if (kind == 3) ry = 10'($urandom_range(480, 1023));
      rf = mk_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rx, ry);
      if (kind == 1) rf[7:0] = rf[7:0] ^ 8'($urandom_range(1, 255));
      if (kind == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk[7:4] == HDR_TAG_DEF) junk[7:4] = 4'h3;
        send_byte(junk, $urandom_range(0, 3));
      end else begin
        send_frame(rf, $urandom_range(0, 3));
      end
    end
    rnd_mode = 0;
    clear_err = 1'b0;
    drain();
    clr();

    // reset mid-frame with a pending command and a sticky flag
    send_frame(GOOD, 0);
    send_byte(8'h3C, 0);
    send_byte(8'hAD, 0); send_byte(8'h00, 0); send_byte(8'h64, 0);
    reset = 1'b1;
    #2;
    check("mrst_valid", 64'(bus.cmd_valid), 64'd0);
    check("mrst_x",     64'(bus.cmd_x), 64'd0);
    check("mrst_brush", 64'(bus.cmd_brush), 64'd0);
    check("mrst_err",   64'(err_flags), 64'd0);
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    send_frame(GOOD, 0);
    check("post_valid", 64'(bus.cmd_valid), 64'd1);
    check("post_y",     64'(bus.cmd_y), 64'd200);
    check("post_err",   64'(err_flags), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
